pwm_deadtime: RTL

Complementary-output stage placed directly downstream of `pwm_generator`. Takes its single `pwm_out` stream and drives a high-side/low-side gate pair with programmable dead time and latched fault shutdown. Guarantees `hs_out` and `ls_out` are never high together.

---
 rtl/pwm_pkg.sv | 16 +
 rtl/pwm_dt_counter.sv | 24 ++
 rtl/pwm_deadtime.sv | 72 +++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: constants and one-hot state encoding shared by the PWM output chain.
package pwm_pkg;
    localparam int CLOCK_FREQ   = 100_000_000;
    localparam int DT_WIDTH_DEF = 8;
    typedef enum logic [5:0] {
        ST_IDLE       = 6'b000001,
        ST_DEAD_TO_HS = 6'b000010,
        ST_HS_ON      = 6'b000100,
        ST_DEAD_TO_LS = 6'b001000,
        ST_LS_ON      = 6'b010000,
        ST_FAULT      = 6'b100000
    } dt_state_e;
    function automatic logic is_dead(input dt_state_e s);
        return s == ST_DEAD_TO_HS || s == ST_DEAD_TO_LS;
    endfunction
endpackage

// File: rtl/pwm_dt_counter.sv
// pwm_dt_counter: dead-time down counter with load and terminal count at 1.
module pwm_dt_counter
    import pwm_pkg::*;
#(
    parameter int DT_WIDTH = DT_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_load,
    input  logic [DT_WIDTH-1:0] i_load_val,
    input  logic                i_dec,
    output logic                o_tc
);
    logic [DT_WIDTH-1:0] r_cnt;
    always_ff @(posedge clk) begin
        if (reset)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (i_dec && r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end
    assign o_tc = r_cnt == DT_WIDTH'(1);
endmodule

// File: rtl/pwm_deadtime.sv
// pwm_deadtime: complementary high/low gate drive with dead time and latched fault trip.
module pwm_deadtime
    import pwm_pkg::*;
#(
    parameter int DT_WIDTH = DT_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pwm_in,
    input  logic                enable,
    input  logic [DT_WIDTH-1:0] dead_cycles,
    input  logic                fault_in,
    input  logic                fault_clr,
    output logic                hs_out,
    output logic                ls_out,
    output logic                fault_latched
);
    dt_state_e r_state;
    logic      r_pwm_q;
    logic      w_tc;
    logic      w_dt_zero;
    logic      w_load;
    assign w_dt_zero = dead_cycles == '0;
    // counter loads on exactly the edges where the FSM enters a dead state
    assign w_load = !reset && !fault_in && enable && !w_dt_zero &&
                    (r_state == ST_IDLE ||
                     (r_state == ST_HS_ON && !r_pwm_q) ||
                     (r_state == ST_LS_ON && r_pwm_q));
    pwm_dt_counter #(.DT_WIDTH(DT_WIDTH)) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (dead_cycles),
        .i_dec      (is_dead(r_state)),
        .o_tc       (w_tc)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_pwm_q <= 1'b0;
        end else begin
            r_pwm_q <= pwm_in;
            if (fault_in)
                r_state <= ST_FAULT;
            else if (r_state == ST_FAULT)
                r_state <= fault_clr ? ST_IDLE : ST_FAULT;
            else if (!enable)
                r_state <= ST_IDLE;
            else begin
                case (r_state)
                    ST_IDLE:
                        r_state <= r_pwm_q ? (w_dt_zero ? ST_HS_ON : ST_DEAD_TO_HS)
                                           : (w_dt_zero ? ST_LS_ON : ST_DEAD_TO_LS);
                    // a pulse that ends inside the dead time returns without waiting
                    ST_DEAD_TO_HS:
                        r_state <= !r_pwm_q ? ST_LS_ON : (w_tc ? ST_HS_ON : ST_DEAD_TO_HS);
                    ST_HS_ON:
                        r_state <= r_pwm_q ? ST_HS_ON : (w_dt_zero ? ST_LS_ON : ST_DEAD_TO_LS);
                    ST_DEAD_TO_LS:
                        r_state <= r_pwm_q ? ST_HS_ON : (w_tc ? ST_LS_ON : ST_DEAD_TO_LS);
                    ST_LS_ON:
                        r_state <= !r_pwm_q ? ST_LS_ON : (w_dt_zero ? ST_HS_ON : ST_DEAD_TO_HS);
                    default:
                        r_state <= ST_IDLE;
                endcase
            end
        end
    end
    assign hs_out        = r_state == ST_HS_ON;
    assign ls_out        = r_state == ST_LS_ON;
    assign fault_latched = r_state == ST_FAULT;
endmodule
